// File: rtl/io_read_arbiter.sv
// I/O cycle sequencer: one-shot read/write strobes, fixed-priority read arbitration
// and a held read byte. Define IO_CONFLICT_COUNT_EN to add the saturating conflict counter.
module io_read_arbiter #(
  parameter int             N_SRC     = 4,
  parameter int             SETTLE    = 2,
  parameter logic [7:0]     IDLE_DATA = 8'hFF
) (
  input  logic               clk28,
  input  logic               rst,
  input  logic               ioreq,
  input  logic               rd,
  input  logic               wr,
  input  logic               m1,
  input  logic               clkcpu_ck,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic               conflict_clr,
  output logic               rd_strobe,
  output logic               wr_strobe,
  output logic [N_SRC-1:0]   grant,
  output logic [7:0]         d_out,
  output logic               d_out_active,
  output logic               conflict,
  output logic [7:0]         conflict_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RD_HOLD,
    S_WR_WAIT,
    S_WR_HOLD
  } state_t;

  localparam logic [N_SRC-1:0] SRC_ONE    = N_SRC'(1);
  localparam logic [2:0]       SETTLE_CNT = 3'(SETTLE - 1);

  state_t           state;
  logic [2:0]       settle_cnt;
  logic             armed;
  logic [N_SRC-1:0] sel_grant;
  logic [7:0]       sel_data;
  logic             found;
  logic             multi_req;
  logic             read_start;
  logic             write_start;

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    sel_grant = '0;
    sel_data  = IDLE_DATA;
    found     = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i] && !found) begin
        sel_grant[i] = 1'b1;
        sel_data     = src_data[8*i +: 8];
        found        = 1'b1;
      end
    end
  end

  assign multi_req   = |(req & (req - SRC_ONE));
  assign read_start  = armed && ioreq && !m1 && rd && !wr;
  assign write_start = armed && ioreq && !m1 && wr && !rd;

  // armed stays low after reset until ioreq is seen low, so a cycle already in
  // flight at reset release is never serviced part-way through.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      armed        <= 1'b0;
      grant        <= '0;
      d_out        <= IDLE_DATA;
      d_out_active <= 1'b0;
      rd_strobe    <= 1'b0;
      wr_strobe    <= 1'b0;
      conflict     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here see pre-edge values, whatever the statement order.
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      conflict  <= 1'b0;
      if (!ioreq) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (read_start) begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_CNT;
          end else if (write_start) begin
            state <= S_WR_WAIT;
          end
        end

        S_SETTLE: begin
          if (!ioreq || !rd) begin
            state <= S_IDLE;
          end else if (settle_cnt == 3'd0) begin
            rd_strobe    <= 1'b1;
            conflict     <= multi_req;
            grant        <= sel_grant;
            d_out        <= sel_data;
            d_out_active <= |req;
            state        <= S_RD_HOLD;
          end else begin
            settle_cnt <= settle_cnt - 3'd1;
          end
        end

        S_RD_HOLD: begin
          if (!ioreq || !rd) begin
            grant        <= '0;
            d_out        <= IDLE_DATA;
            d_out_active <= 1'b0;
            state        <= S_IDLE;
          end
        end

        S_WR_WAIT: begin
          if (!ioreq) begin
            state <= S_IDLE;
          end else if (clkcpu_ck) begin
            wr_strobe <= 1'b1;
            state     <= S_WR_HOLD;
          end
        end

        S_WR_HOLD: begin
          if (!ioreq) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IO_CONFLICT_COUNT_EN
  logic [7:0] conflict_cnt_q;

  // A clear wins over an increment landing on the same edge.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else if (conflict_clr) begin
      conflict_cnt_q <= '0;
    end else if (conflict && conflict_cnt_q != 8'hFF) begin
      conflict_cnt_q <= conflict_cnt_q + 8'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  logic unused_conflict_clr;

  assign unused_conflict_clr = conflict_clr;
  assign conflict_cnt        = 8'h00;
`endif

endmodule

// File: tb/tb_io_read_arbiter.sv
// Directed bench for io_read_arbiter: reads, priority, writes, aborts, reset and
// conflict counting. Expectations for conflict_cnt follow IO_CONFLICT_COUNT_EN.
module tb_io_read_arbiter;

`ifdef IO_CONFLICT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk28 = 1'b0;
  logic        rst;
  logic        ioreq, rd, wr, m1, clkcpu_ck;
  logic [3:0]  req;
  logic [31:0] src_data;
  logic        conflict_clr;
  logic        rd_strobe, wr_strobe;
  logic [3:0]  grant;
  logic [7:0]  d_out;
  logic        d_out_active;
  logic        conflict;
  logic [7:0]  conflict_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_rd  = 0;
  int n_wr  = 0;
  int n_cf  = 0;
  int base_rd, base_wr, base_cf;
  int exp_cnt;

  io_read_arbiter #(.N_SRC(4), .SETTLE(2), .IDLE_DATA(8'hFF)) dut (
    .clk28       (clk28),
    .rst         (rst),
    .ioreq       (ioreq),
    .rd          (rd),
    .wr          (wr),
    .m1          (m1),
    .clkcpu_ck   (clkcpu_ck),
    .req         (req),
    .src_data    (src_data),
    .conflict_clr(conflict_clr),
    .rd_strobe   (rd_strobe),
    .wr_strobe   (wr_strobe),
    .grant       (grant),
    .d_out       (d_out),
    .d_out_active(d_out_active),
    .conflict    (conflict),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk28 = ~clk28;

  // Pulse counters, sampled at the same falling edge the main sequence uses.
  always @(negedge clk28) begin
    if (!rst) begin
      n_rd = n_rd + int'(rd_strobe);
      n_wr = n_wr + int'(wr_strobe);
      n_cf = n_cf + int'(conflict);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic bus_idle();
    ioreq = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    m1    = 1'b0;
  endtask

  task automatic start_read();
    ioreq = 1'b1;
    rd    = 1'b1;
    wr    = 1'b0;
    m1    = 1'b0;
  endtask

  task automatic mark();
    base_rd = n_rd;
    base_wr = n_wr;
    base_cf = n_cf;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  initial begin
    rst          = 1'b1;
    clkcpu_ck    = 1'b0;
    req          = '0;
    src_data     = '0;
    conflict_clr = 1'b0;
    exp_cnt      = 0;
    bus_idle();

    // Reset state
    step(1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_d_out", 32'(d_out), 32'hFF);
    check("rst_active", 32'(d_out_active), 32'h0);
    check("rst_strobes", 32'({rd_strobe, wr_strobe, conflict}), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    rst = 1'b0;
    step(3);

    // Single responder read: grant valid two edges after detection
    mark();
    req      = 4'b0100;
    src_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    start_read();
    step(2);
    check("rd1_early_grant", 32'(grant), 32'h0);
    check("rd1_early_strobe", 32'(rd_strobe), 32'h0);
    step(1);
    check("rd1_strobe", 32'(rd_strobe), 32'h1);
    check("rd1_grant", 32'(grant), 32'h4);
    check("rd1_d_out", 32'(d_out), 32'hA5);
    check("rd1_active", 32'(d_out_active), 32'h1);
    req      = 4'b0001;
    src_data = 32'h3C3C3C3C;
    step(1);
    check("rd1_strobe_once", 32'(rd_strobe), 32'h0);
    check("rd1_hold_grant", 32'(grant), 32'h4);
    check("rd1_hold_data", 32'(d_out), 32'hA5);
    step(4);
    bus_idle();
    check("rd1_active_before_end", 32'(d_out_active), 32'h1);
    step(1);
    check("rd1_active_end", 32'(d_out_active), 32'h0);
    check("rd1_d_out_end", 32'(d_out), 32'hFF);
    check("rd1_grant_end", 32'(grant), 32'h0);
    step(1);
    check("rd1_strobe_count", 32'(n_rd - base_rd), 32'd1);

    // Priority with conflict
    mark();
    req      = 4'b0110;
    src_data = {8'h00, 8'h22, 8'h11, 8'h00};
    start_read();
    step(3);
    check("pri_grant", 32'(grant), 32'h2);
    check("pri_d_out", 32'(d_out), 32'h11);
    check("pri_conflict", 32'(conflict), 32'h1);
    step(1);
    check("pri_conflict_pulse", 32'(conflict), 32'h0);
    exp_cnt = CNT_EN ? 1 : 0;
    check("pri_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    bus_idle();
    step(2);
    check("pri_conflict_count", 32'(n_cf - base_cf), 32'd1);

    // No responder
    mark();
    req = 4'b0000;
    start_read();
    step(3);
    check("none_strobe", 32'(rd_strobe), 32'h1);
    check("none_active", 32'(d_out_active), 32'h0);
    check("none_d_out", 32'(d_out), 32'hFF);
    check("none_grant", 32'(grant), 32'h0);
    bus_idle();
    step(2);

    // Write: clkcpu_ck seen at edges 3, 7, 11 after detection at edge 1
    mark();
    ioreq = 1'b1;
    wr    = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      clkcpu_ck = (i % 4 == 3);
      step(1);
      if (i == 2) check("wr_no_strobe_ck_low", 32'(wr_strobe), 32'h0);
      if (i == 3) check("wr_strobe_after_ck", 32'(wr_strobe), 32'h1);
      if (i == 4) check("wr_strobe_one_cycle", 32'(wr_strobe), 32'h0);
    end
    clkcpu_ck = 1'b0;
    bus_idle();
    step(2);
    check("wr_strobe_count", 32'(n_wr - base_wr), 32'd1);
    check("wr_no_rd_strobe", 32'(n_rd - base_rd), 32'd0);

    // Interrupt acknowledge and illegal rd+wr produce nothing
    mark();
    req = 4'b0001;
    start_read();
    m1 = 1'b1;
    step(6);
    bus_idle();
    step(1);
    ioreq = 1'b1;
    rd    = 1'b1;
    wr    = 1'b1;
    step(6);
    bus_idle();
    step(2);
    check("inta_illegal_strobes", 32'(n_rd - base_rd + n_wr - base_wr), 32'd0);

    // Read aborted after one edge in SETTLE, then a clean read proves IDLE
    mark();
    req      = 4'b1000;
    src_data = {8'h77, 8'h00, 8'h00, 8'h00};
    start_read();
    step(1);
    rd = 1'b0;
    step(4);
    check("abort_grant", 32'(grant), 32'h0);
    check("abort_no_strobe", 32'(n_rd - base_rd), 32'd0);
    ioreq = 1'b0;
    step(1);
    start_read();
    step(3);
    check("after_abort_grant", 32'(grant), 32'h8);
    check("after_abort_d_out", 32'(d_out), 32'h77);
    bus_idle();
    step(2);

    // Reset during RD_HOLD, with the cycle still in flight at release
    req      = 4'b0001;
    src_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    start_read();
    step(4);
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_d_out", 32'(d_out), 32'hFF);
    check("midrst_active", 32'(d_out_active), 32'h0);
    exp_cnt = 0;
    check("midrst_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    step(1);
    rst = 1'b0;
    mark();
    step(6);
    check("post_rst_no_strobe", 32'(n_rd - base_rd), 32'd0);
    check("post_rst_no_grant", 32'(grant), 32'h0);
    bus_idle();
    step(1);
    start_read();
    step(3);
    check("post_rst_grant", 32'(grant), 32'h1);
    check("post_rst_d_out", 32'(d_out), 32'h5A);
    bus_idle();
    step(2);

    // 300 conflicting reads saturate the counter
    req      = 4'b0011;
    src_data = 32'h00004433;
    for (int k = 0; k < 300; k++) begin
      start_read();
      step(3);
      bus_idle();
      step(1);
    end
    step(1);
    exp_cnt = CNT_EN ? sat_add(exp_cnt, 300) : 0;
    check("sat_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // Clear coinciding with a conflict pulse wins
    start_read();
    step(3);
    check("clr_conflict_seen", 32'(conflict), 32'h1);
    conflict_clr = 1'b1;
    step(1);
    conflict_clr = 1'b0;
    exp_cnt = 0;
    check("clr_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    bus_idle();
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
